// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Contents: FSM state encoding, default register-index width.
// Latency/backpressure: n/a (types only).
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam int REG_W_DEF = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline and its hazard controller.
// slave: controller view (hazard/branch/SRAM status in, freeze/flush/stats out).
// master: pipeline view (the reverse); no handshake, every signal is sampled each cycle.
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] idSrc1;
  logic [REG_W-1:0] idSrc2;
  logic             idTwoSrc;
  logic             idUsesSrc1;
  logic             exeWbEn;
  logic [REG_W-1:0] exeDest;
  logic             exeMemRead;
  logic             memWbEn;
  logic [REG_W-1:0] memDest;
  logic             fwdEn;
  logic             branchTaken;
  logic             memReq;
  logic             memReady;
  logic             pcFreeze;
  logic             ifidFreeze;
  logic             ifidFlush;
  logic             idexFlush;
  logic             pipeFreeze;
  logic             memTimeout;
  state_t           state;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  modport slave (
    input  idSrc1, idSrc2, idTwoSrc, idUsesSrc1, exeWbEn, exeDest, exeMemRead,
           memWbEn, memDest, fwdEn, branchTaken, memReq, memReady,
    output pcFreeze, ifidFreeze, ifidFlush, idexFlush, pipeFreeze, memTimeout,
           state, stallCnt, flushCnt
  );

  modport master (
    output idSrc1, idSrc2, idTwoSrc, idUsesSrc1, exeWbEn, exeDest, exeMemRead,
           memWbEn, memDest, fwdEn, branchTaken, memReq, memReady,
    input  pcFreeze, ifidFreeze, ifidFlush, idexFlush, pipeFreeze, memTimeout,
           state, stallCnt, flushCnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_raw_hazard_detect.sv
// RAW hazard detect: ID sources vs EXE/MEM destinations.
// Latency: purely combinational. Backpressure: none.
// Ports: ID sources + use flags, EXE/MEM writeback info, fwd_en in; hazard out.
module raw_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             uses_src1,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_mem_read,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             fwd_en,
  output logic             hazard
);
  logic match_e1, match_e2, match_m1, match_m2;
  logic hit_e, hit_m;

  assign match_e1 = uses_src1 && (src1 == exe_dest);
  assign match_e2 = two_src   && (src2 == exe_dest);
  assign match_m1 = uses_src1 && (src1 == mem_dest);
  assign match_m2 = two_src   && (src2 == mem_dest);

  // With forwarding only a load in EXE cannot be bypassed in time; MEM results always can.
  assign hit_e  = exe_wb_en && (match_e1 || match_e2) && (!fwd_en || exe_mem_read);
  assign hit_m  = !fwd_en && mem_wb_en && (match_m1 || match_m2);
  assign hazard = hit_e || hit_m;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Single freeze/flush source for the 5-stage pipeline: RAW stalls, branch flush, SRAM wait FSM.
// Latency: freeze/flush outputs same-cycle from state+inputs; state, memTimeout, counters registered.
// Backpressure: a pending SRAM access freezes the whole pipe until memReady or timeout (ERROR until rst).
// Ports: clk, rst (sync active-high), bus (slave modport carrying all pipeline-facing signals).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   bus
);
  state_t           state_q, state_d;
  logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             tmo_q, tmo_set;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             hazard;
  logic             mem_stall;
  logic             frozen;

  raw_hazard_detect #(.REG_W(REG_W)) u_raw (
    .src1         (bus.idSrc1),
    .src2         (bus.idSrc2),
    .uses_src1    (bus.idUsesSrc1),
    .two_src      (bus.idTwoSrc),
    .exe_wb_en    (bus.exeWbEn),
    .exe_dest     (bus.exeDest),
    .exe_mem_read (bus.exeMemRead),
    .mem_wb_en    (bus.memWbEn),
    .mem_dest     (bus.memDest),
    .fwd_en       (bus.fwdEn),
    .hazard       (hazard)
  );

  // A request that completes in the same cycle costs nothing.
  assign mem_stall = bus.memReq && !bus.memReady;

  // Everything except "RUN without a stall" and "MEM_WAIT on its ready cycle" holds the whole pipe.
  assign frozen = !((state_q == RUN && !mem_stall) || (state_q == MEM_WAIT && bus.memReady));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (tmo_set) tmo_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tmo_set    = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = TMO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.memReady) begin
          state_d = RUN;
        end else if (wait_cnt_q == TMO_W'(MEM_TIMEOUT)) begin
          state_d = ERROR;
          tmo_set = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TMO_W'(1);
        end
      end
      default: state_d = ERROR;
    endcase
  end

  // Output logic. Branch outranks the RAW stall: the ID instruction is being squashed anyway.
  // In MEM_WAIT a branch is ignored while frozen; EXE re-presents it after release.
  always_comb begin
    bus.pcFreeze   = 1'b0;
    bus.ifidFreeze = 1'b0;
    bus.ifidFlush  = 1'b0;
    bus.idexFlush  = 1'b0;
    bus.pipeFreeze = 1'b0;
    if (rst) begin
      bus.ifidFlush = 1'b1;
      bus.idexFlush = 1'b1;
    end else if (frozen) begin
      bus.pcFreeze   = 1'b1;
      bus.ifidFreeze = 1'b1;
      bus.pipeFreeze = 1'b1;
    end else if (bus.branchTaken) begin
      bus.ifidFlush = 1'b1;
      bus.idexFlush = 1'b1;
    end else if (hazard) begin
      bus.pcFreeze   = 1'b1;
      bus.ifidFreeze = 1'b1;
      bus.idexFlush  = 1'b1;
    end
  end

  // Saturating statistics; flushes during reset are not branch flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.pcFreeze && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (bus.ifidFlush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.state      = state_q;
  assign bus.memTimeout = tmo_q;
  assign bus.stallCnt   = stall_cnt_q;
  assign bus.flushCnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a queue-based scoreboard.
// Driver applies one vector per cycle and queues its expected outputs; monitor checks each on negedge.
// Small MEM_TIMEOUT and counter width make the timeout and saturation paths reachable.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_W(4), .CNT_W(4)) bus ();

  pipe_hazard_ctrl #(.REG_W(4), .TMO_W(8), .MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       two;
    logic       use1;
    logic       ewb;
    logic [3:0] edst;
    logic       emr;
    logic       mwb;
    logic [3:0] mdst;
    logic       fwd;
    logic       br;
    logic       mreq;
    logic       mrdy;
  } in_t;

  // ctl = {pcFreeze, ifidFreeze, ifidFlush, idexFlush, pipeFreeze}
  typedef struct packed {
    int         vec;
    logic [4:0] ctl;
    logic [1:0] st;
    logic [3:0] stall;
    logic [3:0] flush;
    logic       tmo;
    logic       chk_reg;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   vec_no = 0;

  localparam logic [4:0] NONE   = 5'b00000;
  localparam logic [4:0] HAZ    = 5'b11010;
  localparam logic [4:0] FLUSH  = 5'b00110;
  localparam logic [4:0] FREEZE = 5'b11001;

  task automatic chk(input string nm, input int vec, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, vec, act, exp);
    end
  endtask

  task automatic run(input in_t v, input logic [4:0] ctl, input logic [1:0] st,
                     input int stall, input int flush, input logic tmo, input logic chk_reg);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = v.rst;
    bus.idSrc1      = v.src1;
    bus.idSrc2      = v.src2;
    bus.idTwoSrc    = v.two;
    bus.idUsesSrc1  = v.use1;
    bus.exeWbEn     = v.ewb;
    bus.exeDest     = v.edst;
    bus.exeMemRead  = v.emr;
    bus.memWbEn     = v.mwb;
    bus.memDest     = v.mdst;
    bus.fwdEn       = v.fwd;
    bus.branchTaken = v.br;
    bus.memReq      = v.mreq;
    bus.memReady    = v.mrdy;
    vec_no++;
    e.vec     = vec_no;
    e.ctl     = ctl;
    e.st      = st;
    e.stall   = 4'(stall);
    e.flush   = 4'(flush);
    e.tmo     = tmo;
    e.chk_reg = chk_reg;
    q.push_back(e);
  endtask

  // Monitor: outputs are sampled mid-cycle, well away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ctl", e.vec, 32'({bus.pcFreeze, bus.ifidFreeze, bus.ifidFlush, bus.idexFlush, bus.pipeFreeze}), 32'(e.ctl));
        if (e.chk_reg) begin
          chk("state", e.vec, 32'(bus.state), 32'(e.st));
          chk("stallCnt", e.vec, 32'(bus.stallCnt), 32'(e.stall));
          chk("flushCnt", e.vec, 32'(bus.flushCnt), 32'(e.flush));
          chk("memTimeout", e.vec, 32'(bus.memTimeout), 32'(e.tmo));
        end
      end
    end
  end

  initial begin
    in_t v;
    v = '0;
    rst = 1'b1;
    bus.idSrc1 = '0; bus.idSrc2 = '0; bus.idTwoSrc = 0; bus.idUsesSrc1 = 0;
    bus.exeWbEn = 0; bus.exeDest = '0; bus.exeMemRead = 0; bus.memWbEn = 0;
    bus.memDest = '0; bus.fwdEn = 0; bus.branchTaken = 0; bus.memReq = 0; bus.memReady = 0;

    // Reset: flushes asserted, registers cleared
    v = '0; v.rst = 1;
    run(v, FLUSH, 2'd0, 0, 0, 0, 0);
    run(v, FLUSH, 2'd0, 0, 0, 0, 1);

    // Load-use with forwarding
    v = '0; v.fwd = 1; v.emr = 1; v.ewb = 1; v.edst = 3; v.src1 = 3; v.use1 = 1;
    run(v, HAZ, 2'd0, 0, 0, 0, 1);
    v.emr = 0;
    run(v, NONE, 2'd0, 1, 0, 0, 1);
    v.emr = 1; v.use1 = 0;                    // source not read
    run(v, NONE, 2'd0, 1, 0, 0, 1);

    // No forwarding: MEM hit on src2, then src2 unused
    v = '0; v.mwb = 1; v.mdst = 5; v.two = 1; v.src2 = 5;
    run(v, HAZ, 2'd0, 1, 0, 0, 1);
    v.two = 0;
    run(v, NONE, 2'd0, 2, 0, 0, 1);
    // No forwarding: plain EXE hit; with forwarding it disappears; MEM hit bypassed
    v = '0; v.ewb = 1; v.edst = 7; v.src1 = 7; v.use1 = 1;
    run(v, HAZ, 2'd0, 2, 0, 0, 1);
    v.fwd = 1;
    run(v, NONE, 2'd0, 3, 0, 0, 1);
    v = '0; v.fwd = 1; v.mwb = 1; v.mdst = 5; v.src1 = 5; v.use1 = 1;
    run(v, NONE, 2'd0, 3, 0, 0, 1);

    // Branch beats concurrent load-use hazard
    v = '0; v.fwd = 1; v.emr = 1; v.ewb = 1; v.edst = 3; v.src1 = 3; v.use1 = 1; v.br = 1;
    run(v, FLUSH, 2'd0, 3, 0, 0, 1);
    v = '0;
    run(v, NONE, 2'd0, 3, 1, 0, 1);

    // SRAM wait: 3 low-ready cycles then release
    v = '0; v.rst = 1;
    run(v, FLUSH, 2'd0, 3, 1, 0, 1);
    v = '0; v.mreq = 1;
    run(v, FREEZE, 2'd0, 0, 0, 0, 1);
    run(v, FREEZE, 2'd1, 1, 0, 0, 1);
    run(v, FREEZE, 2'd1, 2, 0, 0, 1);
    v.mrdy = 1;
    run(v, NONE, 2'd1, 3, 0, 0, 1);
    v = '0;
    run(v, NONE, 2'd0, 3, 0, 0, 1);
    // Same-cycle ready in RUN: no stall
    v = '0; v.mreq = 1; v.mrdy = 1;
    run(v, NONE, 2'd0, 3, 0, 0, 1);
    // Branch on the release cycle is acted on
    v = '0; v.mreq = 1;
    run(v, FREEZE, 2'd0, 3, 0, 0, 1);
    v.mrdy = 1; v.br = 1;
    run(v, FLUSH, 2'd1, 4, 0, 0, 1);
    v = '0;
    run(v, NONE, 2'd0, 4, 1, 0, 1);

    // Timeout: 4 wait cycles then ERROR; branches ignored while waiting
    v = '0; v.mreq = 1;
    run(v, FREEZE, 2'd0, 4, 1, 0, 1);
    v.br = 1;
    run(v, FREEZE, 2'd1, 5, 1, 0, 1);
    run(v, FREEZE, 2'd1, 6, 1, 0, 1);
    v.br = 0;
    run(v, FREEZE, 2'd1, 7, 1, 0, 1);
    run(v, FREEZE, 2'd1, 8, 1, 0, 1);
    v.mrdy = 1;                               // ERROR ignores late ready
    run(v, FREEZE, 2'd2, 9, 1, 1, 1);
    v = '0; v.br = 1;
    run(v, FREEZE, 2'd2, 10, 1, 1, 1);
    // Stall counter saturates at all-ones
    v = '0;
    for (int i = 0; i < 6; i++) begin
      run(v, FREEZE, 2'd2, (11 + i > 15) ? 15 : 11 + i, 1, 1, 1);
    end
    v.rst = 1;
    run(v, FLUSH, 2'd2, 15, 1, 1, 1);
    v = '0;
    run(v, NONE, 2'd0, 0, 0, 0, 1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
